cache_data_port: RTL and testbench
==================================

# cache_data_port

Requester-side controller for the cache data array. It accepts word-granular read/write requests from the cache pipeline over a valid/ready handshake and drives the data memory's `data_req`/`data_write` port. It returns read data one cycle after acceptance. Partial (byte-masked) writes are converted into a read-modify-write pair. It sits between the cache controller and the single-port data memory, which has registered read data, 1-cycle latency and read-before-write.

## Interface
- `DATA_WIDTH`, 32: width of `cache::cache_data_t`; must be a multiple of 8.
- `INDEX_WIDTH`, 10: width of `cache_req_t.index`; memory depth is 2**INDEX_WIDTH.
- `BE_WIDTH`, DATA_WIDTH/8: byte-enable width (derived).

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req_valid`  in  1  request present.
- `cpu_req_ready`  out  1  request accepted on `cpu_req_valid && cpu_req_ready`.
- `cpu_req_index`  in  INDEX_WIDTH  word index.
- `cpu_req_we`  in  1  1 = write, 0 = read.
- `cpu_req_be`  in  BE_WIDTH  byte enables; writes only.
- `cpu_req_wdata`  in  DATA_WIDTH  write data.
- `cpu_resp_valid`  out  1  read data valid; single-cycle pulse with no back-pressure.
- `cpu_resp_rdata`  out  DATA_WIDTH  read data.
- `data_req`  out  `cache::cache_req_t`  {index, we} to the data memory.
- `data_write`  out  `cache::cache_data_t`  write data to the data memory.
- `data_read`  in  `cache::cache_data_t`  memory read data, valid the cycle after a read is issued.

## Operation
- FSM has two states: IDLE and MERGE.
- `cpu_req_ready` = (state == IDLE) && !reset.
- **IDLE, accepted read:**
  - drive `data_req` = {cpu_req_index, we=0} combinationally in the accept cycle;
  - set the pending-read flag.
- **IDLE, accepted full write (be all ones):**
  - drive `data_req` = {cpu_req_index, we=1} and `data_write` = wdata in the accept cycle;
  - no response; stay in IDLE.
- **IDLE, accepted partial write (be neither 0 nor all ones):**
  - issue read of the index (we=0);
  - latch index, be and wdata;
  - go to MERGE.
- **IDLE, accepted write with be == 0:**
  - no memory access; no response; stay in IDLE.
- **MERGE:**
  - `data_write` byte i = be_q[i] ? wdata_q byte i : `data_read` byte i;
  - `data_req` = {index_q, we=1};
  - `cpu_req_ready` = 0; return to IDLE next cycle.
  - No `cpu_resp_valid` for RMW reads.
- **Response:** `cpu_resp_valid` = pending-read flag (registered); `cpu_resp_rdata` = `data_read` (pass-through).
- **Idle drive:** when no access is issued, `data_req` = {index 0, we=0} and `data_write` = 0.
- **Ordering:**
  - a read issued the cycle after a write to the same index returns the new data;
  - RMW holds off the next request for one cycle, so no stale-merge hazard exists.
- **Reset:**
  - state ← IDLE; pending flag ← 0; `cpu_resp_valid` = 0; `cpu_req_ready` = 0; `data_req.we` = 0; `data_write` = 0;
  - reset asserted in MERGE aborts the write and leaves memory unchanged;
  - a read accepted in the cycle before reset produces no response.

## Timing
- Read latency: acceptance at edge k gives `cpu_resp_valid` high in cycle k+1.
- Reads and full writes sustain 1 request/cycle with ready held high.
- Partial write occupies 2 cycles: ready is low in the MERGE cycle, and the next request is accepted in cycle k+2.
- Memory write commits at the edge ending the issue cycle: the accept cycle for a full write, the MERGE cycle for a partial write.
- Combinational paths: cpu_req_* → data_req/data_write, and data_read → cpu_resp_rdata / merged data_write. No path from cpu_req_valid to cpu_req_ready.

## Structure
- `cache_pkg.sv`:
  - existing `cache_req_t` and `cache_data_t`;
  - add `cache_be_t` (BE_WIDTH);
  - add state enum `cache_port_state_t` {IDLE, MERGE}.
- Sub-module `cache_byte_merge`: purely combinational (old, new, be) → merged. It is reused by later store-buffer work.
- The bench instantiates `data_memory_cache_sim` as the responder.

## Test plan
- Full write idx 5 = 0xDEADBEEF, then read idx 5 in the next cycle → resp_valid one cycle after accept, rdata 0xDEADBEEF; ready never drops.
- Partial write idx 5, be 4'b0011, wdata 0x12345678 after the above → ready low for 1 cycle; read idx 5 returns 0xDEAD5678.
- Back-to-back reads idx 1, 2, 3 (preloaded 0x11, 0x22, 0x33) → resp_valid high for 3 consecutive cycles with rdata 0x11, 0x22, 0x33.
- Write with be 0 to idx 7 (preloaded 0xAAAA5555) → `data_req.we` never asserted; read returns 0xAAAA5555.
- Reset asserted in the MERGE cycle of a partial write to idx 9 (preloaded 0x0) → no write; outputs at reset values; after reset, read idx 9 returns 0x0.
- Random mix of 10k requests against a reference model → every response matches and throughput matches the cycle counts above.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache data array path: word, byte-enable and request types
// plus the data-port controller state encoding.
// No logic; imported by the data port, its byte merger and the memory model.
package cache_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_WIDTH = 10;
    localparam int BE_WIDTH    = DATA_WIDTH / 8;

    typedef logic [DATA_WIDTH-1:0] cache_data_t;
    typedef logic [BE_WIDTH-1:0]   cache_be_t;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic                   we;
    } cache_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } cache_port_state_t;

endpackage

// File: rtl/cache_byte_merge.sv
// Byte-wise merge of new data over old data under a byte-enable mask.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_old (existing word), i_new (incoming word), i_be (1 = take new byte),
//        o_merged (result).
module cache_byte_merge
    import cache_pkg::*;
(
    input  cache_data_t i_old,
    input  cache_data_t i_new,
    input  cache_be_t   i_be,
    output cache_data_t o_merged
);

    for (genvar i = 0; i < BE_WIDTH; i++) begin : g_byte
        assign o_merged[8*i +: 8] = i_be[i] ? i_new[8*i +: 8] : i_old[8*i +: 8];
    end

endmodule

// File: rtl/data_memory_cache_sim.sv
// Single-port data array: registered read data, 1-cycle latency, read-before-write.
// Latency: data_read is valid the cycle after data_req is presented.
// Backpressure: none; accepts an access every cycle.
// Ports: clk, data_req {index, we}, data_write (write word), data_read (registered word).
module data_memory_cache_sim
    import cache_pkg::*;
(
    input  logic        clk,
    input  cache_req_t  data_req,
    input  cache_data_t data_write,
    output cache_data_t data_read
);

    cache_data_t r_mem [2**INDEX_WIDTH];
    cache_data_t r_rdata;

    // Read is taken every cycle before any write, so a write cycle returns the old word.
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[data_req.index];
        if (data_req.we) begin
            r_mem[data_req.index] <= data_write;
        end
    end

    assign data_read = r_rdata;

endmodule

// File: rtl/cache_data_port.sv
// Requester-side controller for the cache data array; partial writes become read-modify-write.
// Latency: read data returned the cycle after acceptance; full writes commit in the accept cycle.
// Backpressure: cpu_req_ready drops for the single MERGE cycle of a partial write and during reset.
// Ports: clk/reset; cpu_req_* request channel (valid/ready); cpu_resp_valid/rdata response
//        (no back-pressure); data_req/data_write/data_read to the single-port data memory.
module cache_data_port
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req_valid,
    output logic                   cpu_req_ready,
    input  logic [INDEX_WIDTH-1:0] cpu_req_index,
    input  logic                   cpu_req_we,
    input  cache_be_t              cpu_req_be,
    input  cache_data_t            cpu_req_wdata,
    output logic                   cpu_resp_valid,
    output cache_data_t            cpu_resp_rdata,
    output cache_req_t             data_req,
    output cache_data_t            data_write,
    input  cache_data_t            data_read
);

    cache_port_state_t      r_state;
    cache_port_state_t      w_state_next;
    logic                   r_pend;
    logic [INDEX_WIDTH-1:0] r_index;
    cache_be_t              r_be;
    cache_data_t            r_wdata;

    logic        w_accept;
    logic        w_latch;
    logic        w_be_full;
    logic        w_be_none;
    cache_data_t w_merged;

    assign cpu_req_ready = (r_state == IDLE) && !reset;
    assign w_accept      = cpu_req_valid && cpu_req_ready;
    assign w_be_full     = &cpu_req_be;
    assign w_be_none     = ~|cpu_req_be;

    // data_read in the MERGE cycle is the old word fetched by the read issued at acceptance.
    cache_byte_merge u_merge (
        .i_old    (data_read),
        .i_new    (r_wdata),
        .i_be     (r_be),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_index <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_accept && !cpu_req_we;
            if (w_latch) begin
                r_index <= cpu_req_index;
                r_be    <= cpu_req_be;
                r_wdata <= cpu_req_wdata;
            end
        end
    end

    // Reset forces the idle drive, which also kills a write pending in MERGE.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        data_req     = '0;
        data_write   = '0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!cpu_req_we) begin
                            data_req = '{index: cpu_req_index, we: 1'b0};
                        end else if (w_be_full) begin
                            data_req   = '{index: cpu_req_index, we: 1'b1};
                            data_write = cpu_req_wdata;
                        end else if (!w_be_none) begin
                            data_req     = '{index: cpu_req_index, we: 1'b0};
                            w_latch      = 1'b1;
                            w_state_next = MERGE;
                        end
                    end
                end
                MERGE: begin
                    data_req     = '{index: r_index, we: 1'b1};
                    data_write   = w_merged;
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // A read accepted just before reset must not report a response during reset.
    assign cpu_resp_valid = r_pend && !reset;
    assign cpu_resp_rdata = data_read;

endmodule

// File: tb/tb_cache_data_port.sv
module tb_cache_data_port;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [9:0]  cpu_req_index;
    logic        cpu_req_we;
    logic [3:0]  cpu_req_be;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    cache_req_t  data_req;
    cache_data_t data_write;
    cache_data_t data_read;

    always #5 clk = ~clk;

    cache_data_port dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_index  (cpu_req_index),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_be     (cpu_req_be),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .data_req       (data_req),
        .data_write     (data_write),
        .data_read      (data_read)
    );

    data_memory_cache_sim u_mem (
        .clk        (clk),
        .data_req   (data_req),
        .data_write (data_write),
        .data_read  (data_read)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    typedef struct {
        bit          we;
        logic [9:0]  idx;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          use_exp;
        logic [31:0] exp;
    } vec_t;

    exp_t        scb[$];
    vec_t        tbl[20];
    logic [31:0] ref_mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          last_partial = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // Advance to the next falling edge and score any response seen there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (scb.size() > 0 && scb[0].due < 32'(cyc)) begin
            checks++;
            errors++;
            $display("FAIL resp_missing: none by cycle %0d, required at cycle %0d", cyc, scb[0].due);
            void'(scb.pop_front());
        end
        if (cpu_resp_valid) begin
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_spurious: got valid rdata %h, required no response", cpu_resp_rdata);
            end else begin
                e = scb.pop_front();
                chk("resp_rdata", cpu_resp_rdata, e.data);
                chk("resp_cycle", 32'(cyc), e.due);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
        last_partial = 1'b0;
    endtask

    // Present one request, check stall count and memory-side drive, then score it.
    task automatic req(input bit we, input logic [9:0] idx, input logic [3:0] be,
                       input logic [31:0] wd, input bit use_exp, input logic [31:0] exp);
        int          stall;
        bit          full, none, part;
        logic [31:0] old, merged;
        exp_t        e;
        stall = 0;
        full  = we && (be == 4'hF);
        none  = we && (be == 4'h0);
        part  = we && !full && !none;
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_index = idx;
        cpu_req_be    = be;
        cpu_req_wdata = wd;
        #1;
        while (!cpu_req_ready && stall < 4) begin
            stall++;
            tick();
            #1;
        end
        if (!cpu_req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready still 0 after %0d cycles, required 1", stall);
            cpu_req_valid = 1'b0;
            return;
        end
        chk("stall_cycles", 32'(stall), last_partial ? 32'd1 : 32'd0);
        chk("issue_index", 32'(data_req.index), none ? 32'd0 : 32'(idx));
        chk("issue_we", 32'(data_req.we), 32'(full));
        chk("issue_wdata", data_write, full ? wd : 32'd0);
        old    = ref_mem[idx];
        merged = mrg(old, wd, be);
        @(posedge clk);
        if (!we) begin
            e.data = use_exp ? exp : old;
            e.due  = 32'(cyc + 1);
            scb.push_back(e);
        end else if (full) begin
            ref_mem[idx] = wd;
        end else if (part) begin
            ref_mem[idx] = merged;
        end
        tick();
        cpu_req_valid = 1'b0;
        if (part) begin
            #1;
            chk("merge_index", 32'(data_req.index), 32'(idx));
            chk("merge_we", 32'(data_req.we), 32'd1);
            chk("merge_wdata", data_write, merged);
        end
        last_partial = part;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 10'd5, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 10'd5, 4'h3, 32'h12345678, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 10'd5, 4'h0, 32'h0,        1'b1, 32'hDEAD5678};
        tbl[4]  = '{1'b1, 10'd1, 4'hF, 32'h11,       1'b0, 32'h0};
        tbl[5]  = '{1'b1, 10'd2, 4'hF, 32'h22,       1'b0, 32'h0};
        tbl[6]  = '{1'b1, 10'd3, 4'hF, 32'h33,       1'b0, 32'h0};
        tbl[7]  = '{1'b0, 10'd1, 4'h0, 32'h0,        1'b1, 32'h11};
        tbl[8]  = '{1'b0, 10'd2, 4'h0, 32'h0,        1'b1, 32'h22};
        tbl[9]  = '{1'b0, 10'd3, 4'h0, 32'h0,        1'b1, 32'h33};
        tbl[10] = '{1'b1, 10'd7, 4'hF, 32'hAAAA5555, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 10'd7, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 10'd7, 4'h0, 32'h0,        1'b1, 32'hAAAA5555};
        tbl[13] = '{1'b1, 10'd5, 4'hC, 32'hCAFE0000, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 10'd5, 4'h0, 32'h0,        1'b1, 32'hCAFE5678};
        tbl[15] = '{1'b1, 10'd5, 4'h4, 32'h00990000, 1'b0, 32'h0};
        tbl[16] = '{1'b1, 10'd6, 4'h9, 32'hA1B2C3D4, 1'b0, 32'h0};
        tbl[17] = '{1'b0, 10'd5, 4'h0, 32'h0,        1'b1, 32'hCA995678};
        tbl[18] = '{1'b1, 10'd9, 4'hF, 32'h0,        1'b0, 32'h0};
        tbl[19] = '{1'b0, 10'd9, 4'h0, 32'h0,        1'b1, 32'h0};
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_index = '0;
        cpu_req_be    = '0;
        cpu_req_wdata = '0;
        tick();
        tick();
        chk("rst_ready", 32'(cpu_req_ready), 32'd0);
        chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        chk("rst_req_we", 32'(data_req.we), 32'd0);
        chk("rst_wdata", data_write, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cpu_req_ready), 32'd1);

        for (int i = 0; i < 20; i++) begin
            req(tbl[i].we, tbl[i].idx, tbl[i].be, tbl[i].wd, tbl[i].use_exp, tbl[i].exp);
        end
        idle(3);
        chk("queue_drained_tbl", 32'(scb.size()), 32'd0);

        // Reset during the MERGE cycle of a partial write to idx 9 must drop the write.
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b1;
        cpu_req_index = 10'd9;
        cpu_req_be    = 4'h3;
        cpu_req_wdata = 32'h12345678;
        #1 chk("abort_ready", 32'(cpu_req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        tick();
        chk("abort_req_we", 32'(data_req.we), 32'd0);
        chk("abort_wdata", data_write, 32'd0);
        chk("abort_ready_rst", 32'(cpu_req_ready), 32'd0);
        chk("abort_resp_valid", 32'(cpu_resp_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        req(1'b0, 10'd9, 4'h0, 32'h0, 1'b1, 32'h0);
        idle(2);

        // A read accepted right before reset must never respond.
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_index = 10'd5;
        #1;
        @(posedge clk);
        #1;
        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        tick();
        chk("prerst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("postrst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        idle(1);

        // Random mix over a small index window to force same-index hazards.
        for (int i = 0; i < 16; i++) req(1'b1, 10'(i), 4'hF, $urandom, 1'b0, 32'h0);
        for (int n = 0; n < 10000; n++) begin
            int          op;
            logic [3:0]  rbe;
            op  = $urandom_range(0, 3);
            rbe = 4'($urandom_range(0, 15));
            if (op < 2)       req(1'b0, 10'($urandom_range(0, 15)), 4'h0, 32'h0, 1'b0, 32'h0);
            else if (op == 2) req(1'b1, 10'($urandom_range(0, 15)), 4'hF, $urandom, 1'b0, 32'h0);
            else              req(1'b1, 10'($urandom_range(0, 15)), rbe, $urandom, 1'b0, 32'h0);
        end
        idle(4);
        chk("queue_drained_rand", 32'(scb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
